pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the period/high-time counters and outputs.
REQ-002 Parameter SYNC_STAGES, default 2, sets the number of flops in the pwm_i synchronizer (minimum 2).
REQ-003 core_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 core_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pwm_i  input  1  asynchronous PWM waveform to be measured.
REQ-006 cap_en  input  1  capture enable; 0 holds the block in IDLE.
REQ-007 cap_pol  input  1  polarity; 0 = idle low/active high, 1 = idle high/active low.
REQ-008 period_o  output  CNT_W  last measured period, in core_clk cycles.
REQ-009 high_o  output  CNT_W  last measured active-level duration, in core_clk cycles.
REQ-010 cap_valid  output  1  one-cycle strobe; period_o/high_o updated this cycle.
REQ-011 cap_tmo  output  1  one-cycle strobe; counter saturated with no active edge.
REQ-012 level_o  output  1  synchronized pwm_i after polarity correction (1 = active).

Function
REQ-013 pwm_i SHALL pass through SYNC_STAGES flops; level_o = last sync stage XOR cap_pol.
REQ-014 Active edge = level_o 0->1, inactive edge = level_o 1->0, detected against a one-cycle-delayed copy of level_o.
REQ-015 Edge detection latency SHALL be SYNC_STAGES+1 cycles from the pwm_i transition to the edge-detect cycle.
REQ-016 FSM states: IDLE, ARM, MEAS.
REQ-017 IDLE: counter held at 0; cap_en=1 -> ARM.
REQ-018 ARM: wait for an active edge; on detection -> MEAS, counter := 1.
REQ-019 MEAS: counter increments by 1 each cycle; on an inactive edge, high capture register := current counter value.
REQ-020 MEAS, active edge: period_o := counter, high_o := high capture register, cap_valid = 1 in the next cycle, counter := 1, remain in MEAS.
REQ-021 period_o therefore equals the cycle count between consecutive active-edge detections; high_o equals the count from the active-edge to the inactive-edge detection.
REQ-022 MEAS, counter = all-ones with no active edge in that cycle: cap_tmo = 1 for one cycle, -> ARM; period_o/high_o unchanged.
REQ-023 An active edge in the same cycle as counter = all-ones SHALL be treated as a normal capture (REQ-020), with no timeout.
REQ-024 A period with no inactive edge detected before the active edge (not possible with clean input) SHALL report high_o = period_o.
REQ-025 cap_en = 0 in any state -> IDLE on the next cycle; no cap_valid or cap_tmo is generated and outputs hold their last values.
REQ-026 A change of cap_pol while not in IDLE SHALL force -> ARM, discarding the partial measurement.
REQ-027 cap_valid and cap_tmo SHALL never both be 1 in the same cycle.

Reset
REQ-028 Reset SHALL clear the sync chain, the delayed level, the counter, the high capture register, period_o and high_o to 0; cap_valid, cap_tmo and level_o to 0; FSM to IDLE.
REQ-029 The first capture after reset or after re-arm SHALL require two active edges; the first edge only starts the measurement.

Verification
REQ-030 cap_pol=0, pwm_i 100-cycle period, high for 25 cycles -> from the second period on, cap_valid once per 100 cycles, period_o=100, high_o=25.
REQ-031 cap_pol=1, same waveform -> period_o=100, high_o=75.
REQ-032 CNT_W=8, pwm_i held at 0 after one active edge -> cap_tmo once, 255 cycles after the edge; FSM back in ARM; period_o unchanged.
REQ-033 cap_en dropped mid-period, then raised -> no strobe while disabled; the first cap_valid comes only after two fresh active edges.
REQ-034 core_rst_n asserted mid-MEAS, asynchronous to core_clk -> all outputs 0 immediately; IDLE after release.
REQ-035 Period of exactly 255 cycles at CNT_W=8 -> cap_valid with period_o=255 and no cap_tmo.

Source files
------------

// File: rtl/pwm_capture_if.sv
// Control and result signals of the PWM capture block, bundled for port connection.
// master = the side that drives the waveform and controls; slave = the capture core.
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic             pwm_i;
    logic             cap_en;
    logic             cap_pol;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             cap_valid;
    logic             cap_tmo;
    logic             level_o;

    modport master (
        output pwm_i, cap_en, cap_pol,
        input  period_o, high_o, cap_valid, cap_tmo, level_o
    );

    modport slave (
        input  pwm_i, cap_en, cap_pol,
        output period_o, high_o, cap_valid, cap_tmo, level_o
    );
endinterface

// File: rtl/pwm_capture.sv
// Measures period and active-level duration of an asynchronous PWM input in core_clk
// cycles; flags a timeout when the counter saturates without a new active edge.
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2   // at least 2
) (
    input  logic         core_clk,
    input  logic         core_rst_n,
    pwm_capture_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [SYNC_STAGES-1:0] sync_reg, sync_next;
    logic                   level_reg, level_d_reg, pol_reg;
    logic [CNT_W-1:0]       cnt_reg, high_cap_reg, period_reg, high_reg;
    logic                   high_seen_reg, cap_valid_reg, cap_tmo_reg;
    logic                   raw_lvl, pol_chg, act_edge, inact_edge, cnt_max;
    logic                   start, capture, timeout;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = bus.pwm_i;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign raw_lvl    = sync_reg[SYNC_STAGES-1];
    assign pol_chg    = bus.cap_pol ^ pol_reg;
    assign act_edge   = level_reg & ~level_d_reg;
    assign inact_edge = ~level_reg & level_d_reg;
    assign cnt_max    = (cnt_reg == {CNT_W{1'b1}});

    // On a polarity change the delayed copy is realigned with the new level, so the
    // inversion itself never shows up as an edge.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            sync_reg    <= '0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
            pol_reg     <= 1'b0;
        end else begin
            sync_reg    <= sync_next;
            level_reg   <= raw_lvl ^ bus.cap_pol;
            level_d_reg <= pol_chg ? (raw_lvl ^ bus.cap_pol) : level_reg;
            pol_reg     <= bus.cap_pol;
        end
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        start   = 1'b0;
        capture = 1'b0;
        timeout = 1'b0;
        if (bus.cap_en && !pol_chg) begin
            case (state_reg)
                ARM:     start = act_edge;
                MEAS: begin
                    capture = act_edge;
                    timeout = !act_edge && cnt_max;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!bus.cap_en) begin
            state_next = IDLE;
        end else if (pol_chg && state_reg != IDLE) begin
            state_next = ARM;
        end else begin
            case (state_reg)
                IDLE:    state_next = ARM;
                ARM:     if (act_edge) state_next = MEAS;
                MEAS:    if (timeout) state_next = ARM;
                default: state_next = IDLE;
            endcase
        end
    end

    // high_seen_reg tracks whether this period saw its inactive edge; without one the
    // whole period is reported as active time.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            cnt_reg       <= '0;
            high_cap_reg  <= '0;
            high_seen_reg <= 1'b0;
            period_reg    <= '0;
            high_reg      <= '0;
            cap_valid_reg <= 1'b0;
            cap_tmo_reg   <= 1'b0;
        end else begin
            if (start || capture) begin
                cnt_reg <= CNT_W'(1);
            end else if (state_reg == MEAS && state_next == MEAS) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else begin
                cnt_reg <= '0;
            end

            if (start || capture) begin
                high_seen_reg <= 1'b0;
            end else if (state_reg == MEAS && inact_edge) begin
                high_cap_reg  <= cnt_reg;
                high_seen_reg <= 1'b1;
            end

            if (capture) begin
                period_reg <= cnt_reg;
                high_reg   <= high_seen_reg ? high_cap_reg : cnt_reg;
            end

            cap_valid_reg <= capture;
            cap_tmo_reg   <= timeout;
        end
    end

    assign bus.period_o  = period_reg;
    assign bus.high_o    = high_reg;
    assign bus.cap_valid = cap_valid_reg;
    assign bus.cap_tmo   = cap_tmo_reg;
    assign bus.level_o   = level_reg;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (CNT_W=8): expected strobes are queued as the waveform
// is driven and compared when cap_valid/cap_tmo appear.
module tb_pwm_capture;
    logic clk = 1'b0;
    logic core_rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_cyc = 0;

    typedef struct {
        bit tmo;
        int period;
        int high;
        int gap;
    } exp_t;
    exp_t exp_q[$];

    pwm_capture_if #(.CNT_W(8)) bus ();

    pwm_capture #(.CNT_W(8), .SYNC_STAGES(2)) dut (
        .core_clk   (clk),
        .core_rst_n (core_rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input bit tmo, input int period, input int high, input int gap);
        exp_t e;
        e.tmo = tmo; e.period = period; e.high = high; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            step(1);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic pulse(input int high, input int low);
        bus.pwm_i = 1'b1;
        step(high);
        bus.pwm_i = 1'b0;
        step(low);
    endtask

    // Scoreboard side: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (core_rst_n && (bus.cap_valid || bus.cap_tmo)) begin
            exp_t e;
            $display("strobe cyc=%0d valid=%0b tmo=%0b period=%0d high=%0d",
                     cyc, bus.cap_valid, bus.cap_tmo, bus.period_o, bus.high_o);
            check("exclusive", {31'd0, bus.cap_valid & bus.cap_tmo}, 0);
            check("strobe_expected", {31'd0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("kind_tmo", {31'd0, bus.cap_tmo}, {31'd0, e.tmo});
                check("period_o", {24'd0, bus.period_o}, e.period);
                check("high_o", {24'd0, bus.high_o}, e.high);
                if (e.gap >= 0) check("strobe_gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pwm_i = 1'b0;
        bus.cap_en = 1'b0;
        bus.cap_pol = 1'b0;
        step(3);
        check("rst_period", {24'd0, bus.period_o}, 0);
        check("rst_high", {24'd0, bus.high_o}, 0);
        check("rst_valid", {31'd0, bus.cap_valid}, 0);
        check("rst_tmo", {31'd0, bus.cap_tmo}, 0);
        check("rst_level", {31'd0, bus.level_o}, 0);
        core_rst_n = 1'b1;
        step(2);

        // level_o latency and polarity
        bus.pwm_i = 1'b1;
        step(2);
        check("level_lat2", {31'd0, bus.level_o}, 0);
        step(1);
        check("level_lat3", {31'd0, bus.level_o}, 1);
        bus.cap_pol = 1'b1;
        step(1);
        check("level_pol", {31'd0, bus.level_o}, 0);
        bus.cap_pol = 1'b0;
        bus.pwm_i = 1'b0;
        step(5);
        bus.cap_en = 1'b1;
        step(3);

        // active-high, 100-cycle period, 25 high, then timeout
        for (int p = 0; p < 4; p++) begin
            if (p > 0) push(1'b0, 100, 25, (p == 1) ? -1 : 100);
            pulse(25, 75);
        end
        push(1'b1, 100, 25, 255);
        wait_drain(400);

        // active-low, same waveform
        bus.cap_pol = 1'b1;
        step(3);
        for (int p = 0; p < 4; p++) begin
            bus.pwm_i = 1'b1;
            step(25);
            if (p > 0) push(1'b0, 100, 75, (p == 1) ? -1 : 100);
            bus.pwm_i = 1'b0;
            step(75);
        end
        push(1'b1, 100, 75, 255);
        wait_drain(400);

        // cap_en dropped mid-period
        bus.cap_pol = 1'b0;
        step(3);
        pulse(25, 75);
        push(1'b0, 100, 25, -1);
        pulse(25, 25);
        bus.cap_en = 1'b0;
        step(50);
        bus.pwm_i = 1'b1;
        step(20);
        bus.cap_en = 1'b1;
        step(5);
        bus.pwm_i = 1'b0;
        step(75);
        pulse(25, 75);
        push(1'b0, 100, 25, -1);
        pulse(25, 50);
        bus.cap_en = 1'b0;
        wait_drain(50);
        step(3);
        bus.cap_en = 1'b1;
        step(3);

        // period of exactly 255 cycles: capture, no timeout
        pulse(10, 245);
        push(1'b0, 255, 10, -1);
        pulse(10, 20);
        bus.cap_en = 1'b0;
        wait_drain(50);
        step(3);
        bus.cap_en = 1'b1;
        step(3);

        // polarity glitch mid-measurement discards the partial period
        pulse(25, 75);
        push(1'b0, 100, 25, -1);
        pulse(25, 30);
        bus.cap_pol = 1'b1;
        step(1);
        bus.cap_pol = 1'b0;
        step(44);
        pulse(25, 75);
        push(1'b0, 100, 25, -1);
        bus.pwm_i = 1'b1;
        step(10);
        wait_drain(10);

        // asynchronous reset mid-measurement
        #3;
        core_rst_n = 1'b0;
        bus.pwm_i = 1'b0;
        #1;
        check("arst_period", {24'd0, bus.period_o}, 0);
        check("arst_high", {24'd0, bus.high_o}, 0);
        check("arst_valid", {31'd0, bus.cap_valid}, 0);
        check("arst_tmo", {31'd0, bus.cap_tmo}, 0);
        check("arst_level", {31'd0, bus.level_o}, 0);
        step(2);
        core_rst_n = 1'b1;
        step(5);
        check("post_rst_period", {24'd0, bus.period_o}, 0);
        pulse(25, 75);
        push(1'b0, 100, 25, -1);
        pulse(25, 40);
        bus.cap_en = 1'b0;
        wait_drain(50);
        step(5);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
